// File: rtl/bsg_round_robin_1_to_n_rx_pkg.sv
// bsg_round_robin_1_to_n_rx_pkg
//   Shared helper for the round-robin receive block.
//   safe_clog2(n) : ceil(log2(n)), with a minimum of 1 so that a tag or pointer
//                   field never collapses to zero bits.
package bsg_round_robin_1_to_n_rx_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_round_robin_1_to_n_rx_ptr.sv
// bsg_round_robin_1_to_n_rx_ptr
//   Wrapping slot pointer with an asynchronous clear. It advances by one on each
//   add_i and wraps slots_p-1 -> 0, so non-power-of-two slot counts are supported.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low clear (pointer -> 0)
//   add_i      advance by one this cycle
//   ptr_o      current pointer value
module bsg_round_robin_1_to_n_rx_ptr #(
  parameter int slots_p     = 8,
  parameter int ptr_width_p = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   add_i,
  output logic [ptr_width_p-1:0] ptr_o
);

  localparam logic [ptr_width_p-1:0] last_lp = ptr_width_p'(slots_p - 1);

  logic [ptr_width_p-1:0] ptr_reg;
  logic [ptr_width_p-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (add_i) begin
      ptr_next = (ptr_reg == last_lp) ? '0 : ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_reg <= '0;
    else            ptr_reg <= ptr_next;
  end

  assign ptr_o = ptr_reg;

endmodule

// File: rtl/bsg_round_robin_1_to_n_rx.sv
// bsg_round_robin_1_to_n_rx
//   Receive end of a strict round-robin n-to-1 channel. It takes one serialized
//   stream (data + source tag) and hands each item to one of num_out_p output
//   channels through a single registered stage. The stage gives 1-cycle latency
//   and full throughput.
//   strict_p=1 : the destination comes from an internal rotating pointer, and tag_i
//                is only compared against it (a mismatch sets err_o[0]).
//   strict_p=0 : the destination is tag_i. An out-of-range tag is consumed and
//                dropped, and it sets err_o[0].
// Ports:
//   clk_i, reset_n_i    clock, asynchronous active-low reset
//   v_i, data_i, tag_i  incoming item
//   yumi_o              incoming item consumed this cycle
//   v_o                 per-channel valid (at most one bit high)
//   data_o              payload replicated on every channel slice
//   yumi_i              per-channel consume
//   err_o               sticky: [0] tag mismatch/out-of-range, [1] spurious yumi
module bsg_round_robin_1_to_n_rx
  import bsg_round_robin_1_to_n_rx_pkg::*;
#(
  parameter int num_out_p = 8,
  parameter int width_p   = 32,
  parameter int strict_p  = 1,
  localparam int tag_width_lp = safe_clog2(num_out_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  input  logic [tag_width_lp-1:0]      tag_i,
  output logic                         yumi_o,
  output logic [num_out_p-1:0]         v_o,
  output logic [num_out_p*width_p-1:0] data_o,
  input  logic [num_out_p-1:0]         yumi_i,
  output logic [1:0]                   err_o
);

  logic                    valid_reg;
  logic [width_p-1:0]      data_reg;
  logic [tag_width_lp-1:0] dest_reg;
  logic [1:0]              err_reg;

  logic [tag_width_lp-1:0] ptr;
  logic [tag_width_lp-1:0] dest;
  logic                    deq;
  logic                    spurious;
  logic                    tag_out_of_range;
  logic                    tag_err;
  logic                    drop;

  genvar gi;
  generate
    for (gi = 0; gi < num_out_p; gi++) begin : g_out
      assign v_o[gi]                         = valid_reg & (dest_reg == tag_width_lp'(gi));
      assign data_o[gi*width_p +: width_p]   = data_reg;
    end
  endgenerate

  assign deq      = |(yumi_i & v_o);
  assign spurious = |(yumi_i & ~v_o);

  // The output slot is free when it is empty or is being drained this cycle.
  // This allows same-cycle pass-through without a bubble.
  assign yumi_o = v_i & (~valid_reg | deq);

  assign tag_out_of_range = (int'(tag_i) >= num_out_p);
  assign dest             = (strict_p != 0) ? ptr : tag_i;
  assign drop             = (strict_p == 0) & tag_out_of_range;
  assign tag_err          = (strict_p != 0) ? (tag_i != ptr) : tag_out_of_range;

  bsg_round_robin_1_to_n_rx_ptr #(
    .slots_p    (num_out_p),
    .ptr_width_p(tag_width_lp)
  ) ptr_inst (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .add_i    (yumi_o & (strict_p != 0)),
    .ptr_o    (ptr)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_reg <= 1'b0;
      err_reg   <= 2'b00;
    end else begin
      // A dropped item is consumed but never occupies the output slot.
      if (yumi_o)   valid_reg <= ~drop;
      else if (deq) valid_reg <= 1'b0;
      err_reg[0] <= err_reg[0] | (yumi_o & tag_err);
      err_reg[1] <= err_reg[1] | spurious;
    end
  end

  // The payload and destination are only meaningful while valid_reg is set,
  // so they need no reset.
  always_ff @(posedge clk_i) begin
    if (yumi_o & ~drop) begin
      data_reg <= data_i;
      dest_reg <= dest;
    end
  end

  assign err_o = err_reg;

endmodule

// File: tb/tb_bsg_round_robin_1_to_n_rx.sv
module tb_bsg_round_robin_1_to_n_rx;

  typedef struct {
    int          chan;
    logic [31:0] data;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  // DUT A: strict, 8 channels
  logic         v_a;
  logic [31:0]  data_a;
  logic [2:0]   tag_a;
  logic         yumi_o_a;
  logic [7:0]   v_o_a;
  logic [255:0] data_o_a;
  logic [7:0]   yumi_a;
  logic [7:0]   man_a;
  bit           auto_a;
  logic [1:0]   err_a;

  // DUT B: non-strict, 5 channels
  logic         v_b;
  logic [31:0]  data_b;
  logic [2:0]   tag_b;
  logic         yumi_o_b;
  logic [4:0]   v_o_b;
  logic [159:0] data_o_b;
  logic [4:0]   yumi_b;
  bit           auto_b;
  logic [1:0]   err_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    yumi_a = auto_a ? v_o_a : man_a;
    yumi_b = auto_b ? v_o_b : 5'b0;
  end

  bsg_round_robin_1_to_n_rx #(.num_out_p(8), .width_p(32), .strict_p(1)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .data_i(data_a), .tag_i(tag_a),
    .yumi_o(yumi_o_a), .v_o(v_o_a), .data_o(data_o_a), .yumi_i(yumi_a), .err_o(err_a)
  );

  bsg_round_robin_1_to_n_rx #(.num_out_p(5), .width_p(32), .strict_p(0)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .data_i(data_b), .tag_i(tag_b),
    .yumi_o(yumi_o_b), .v_o(v_o_b), .data_o(data_o_b), .yumi_i(yumi_b), .err_o(err_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor A: every dequeue must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && ((v_o_a & yumi_a) != 8'h0)) begin
      int   idx;
      exp_t e;
      idx = -1;
      for (int k = 0; k < 8; k++) if (v_o_a[k]) idx = k;
      chk("A_onehot", 64'($onehot(v_o_a)), 64'd1);
      if (qa.size() == 0) begin
        chk("A_unexpected_deq", 64'(idx), 64'hFFFF);
      end else begin
        e = qa.pop_front();
        $display("deq A ch=%0d data=%08h cycle=%0d", idx, data_o_a[idx*32 +: 32], cyc);
        chk("A_chan", 64'(idx), 64'(e.chan));
        chk("A_data", 64'(data_o_a[idx*32 +: 32]), 64'(e.data));
        if (e.lat) chk("A_latency", 64'(cyc), 64'(e.acc_cyc + 1));
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (rst_n && ((v_o_b & yumi_b) != 5'h0)) begin
      int   idx;
      exp_t e;
      idx = -1;
      for (int k = 0; k < 5; k++) if (v_o_b[k]) idx = k;
      chk("B_onehot", 64'($onehot(v_o_b)), 64'd1);
      if (qb.size() == 0) begin
        chk("B_unexpected_deq", 64'(idx), 64'hFFFF);
      end else begin
        e = qb.pop_front();
        $display("deq B ch=%0d data=%08h cycle=%0d", idx, data_o_b[idx*32 +: 32], cyc);
        chk("B_chan", 64'(idx), 64'(e.chan));
        chk("B_data", 64'(data_o_b[idx*32 +: 32]), 64'(e.data));
      end
    end
  end

  // This task is entered shortly after a rising edge. It drives one item, checks
  // yumi_o at the falling edge, and queues the expected output when the item is
  // expected to be consumed.
  task automatic step_a(input logic [2:0] tag, input logic [31:0] d, input bit exp_yumi,
                        input int chan, input bit lat);
    exp_t e;
    v_a = 1'b1; tag_a = tag; data_a = d;
    @(negedge clk);
    chk("A_yumi_o", 64'(yumi_o_a), 64'(exp_yumi));
    if (exp_yumi) begin
      e.chan = chan; e.data = d; e.acc_cyc = cyc; e.lat = lat;
      qa.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic [2:0] tag, input logic [31:0] d, input bit exp_yumi,
                        input bit exp_out);
    exp_t e;
    v_b = 1'b1; tag_b = tag; data_b = d;
    @(negedge clk);
    chk("B_yumi_o", 64'(yumi_o_b), 64'(exp_yumi));
    if (exp_out) begin
      e.chan = int'(tag); e.data = d; e.acc_cyc = cyc; e.lat = 1'b0;
      qb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_qa", 64'(qa.size()), 64'd0);
    chk("drain_qb", 64'(qb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    automatic logic [2:0] mm_tags [8] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd5, 3'd3};
    rst_n = 1'b0;
    v_a = 0; data_a = 0; tag_a = 0; man_a = 0; auto_a = 0;
    v_b = 0; data_b = 0; tag_b = 0; auto_b = 0;

    #12;
    chk("rst_v_o", 64'(v_o_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_yumi_o", 64'(yumi_o_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-throughput rotation: the tags match the pointer, and the consumer
    // accepts every cycle.
    auto_a = 1;
    for (int i = 0; i < 16; i++) step_a(3'(i % 8), 32'hA0 + 32'(i), 1'b1, i % 8, 1'b1);
    v_a = 0;
    drain();
    chk("rot_err", 64'(err_a), 64'd0);

    // Backpressure: one item is accepted, and then nothing is accepted while the
    // consumer stalls.
    auto_a = 0; man_a = 8'h00;
    step_a(3'd0, 32'hB0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) step_a(3'd1, 32'hB1, 1'b0, 1, 1'b0);
    auto_a = 1;
    step_a(3'd1, 32'hB1, 1'b1, 1, 1'b1);
    step_a(3'd2, 32'hB2, 1'b1, 2, 1'b1);
    step_a(3'd3, 32'hB3, 1'b1, 3, 1'b1);
    v_a = 0;
    drain();

    // Tag mismatch: the pointer is at 4. The item sent with tag 5 while the pointer
    // is 2 still goes to channel 2, and the next item goes to channel 3.
    for (int i = 0; i < 8; i++) begin
      v_a = 1'b1; tag_a = mm_tags[i]; data_a = 32'hC0 + 32'(i);
      @(negedge clk);
      chk("mm_err", 64'(err_a), (i > 6) ? 64'd1 : 64'd0);
      chk("mm_yumi_o", 64'(yumi_o_a), 64'd1);
      qa.push_back('{chan: (i + 4) % 8, data: 32'hC0 + 32'(i), acc_cyc: cyc, lat: 1'b1});
      @(posedge clk); #1;
    end
    v_a = 0;
    drain();
    chk("mm_err_sticky", 64'(err_a), 64'd1);

    // Asynchronous reset while an item is held and the pointer is at 6.
    step_a(3'd4, 32'hD0, 1'b1, 4, 1'b1);
    step_a(3'd5, 32'hD1, 1'b1, 5, 1'b0);
    auto_a = 0; man_a = 8'h00; v_a = 0;
    @(negedge clk);
    chk("hold_v_o", 64'(v_o_a), 64'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v_o", 64'(v_o_a), 64'd0);
    chk("arst_err", 64'(err_a), 64'd0);
    chk("arst_yumi_o", 64'(yumi_o_a), 64'd0);
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // After reset, the first item goes to channel 0. A spurious yumi on channel 4
    // leaves that item in place and sets err_o[1].
    step_a(3'd0, 32'hE0, 1'b1, 0, 1'b0);
    v_a = 0; man_a = 8'h10;
    @(negedge clk);
    chk("spur_v_o", 64'(v_o_a), 64'h01);
    @(posedge clk); #1;
    man_a = 8'h00;
    @(negedge clk);
    chk("spur_err", 64'(err_a), 64'd2);
    chk("spur_v_o_kept", 64'(v_o_a), 64'h01);
    @(posedge clk); #1;
    auto_a = 1;
    step_a(3'd1, 32'hE1, 1'b1, 1, 1'b1);
    v_a = 0;
    drain();
    chk("spur_err_sticky", 64'(err_a), 64'd2);

    // Non-strict with 5 channels: tag 3 is routed, tag 6 is consumed and dropped,
    // and tag 4 is the highest legal channel.
    auto_b = 1;
    chk("B_err_init", 64'(err_b), 64'd0);
    step_b(3'd3, 32'hF0, 1'b1, 1'b1);
    step_b(3'd6, 32'hF1, 1'b1, 1'b0);
    v_b = 0;
    @(negedge clk);
    chk("B_drop_v_o", 64'(v_o_b), 64'd0);
    chk("B_drop_err", 64'(err_b), 64'd1);
    @(posedge clk); #1;
    step_b(3'd4, 32'hF2, 1'b1, 1'b1);
    step_b(3'd0, 32'hF3, 1'b1, 1'b1);
    v_b = 0;
    drain();
    chk("B_err_sticky", 64'(err_b), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
